// File: rtl/u_pkg.sv
// Shared constants and helpers for the unary multiplier test block.
package u_pkg;

    localparam int unsigned WIDTH = 7;
    localparam int unsigned A_DEFAULT = 96;
    localparam int unsigned B_DEFAULT = 64;

    // Reverse all WIDTH bits of a counter value (low-discrepancy sequence index).
    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            r[i] = v[int'(WIDTH) - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/u_sng.sv
// Stochastic number generator: compares the shared counter (optionally
// bit-reversed) against a constant, giving VALUE ones per 2^WIDTH cycles.
module u_sng #(
    parameter int unsigned WIDTH   = u_pkg::WIDTH,
    parameter int unsigned VALUE   = 0,
    parameter bit          REVERSE = 1'b0
) (
    input  logic [WIDTH-1:0] cnt,
    output logic             bit_c
);

    logic [WIDTH-1:0] key;

    if (VALUE > (64'd1 << WIDTH)) begin : g_range_err
        $error("u_sng: VALUE %0d exceeds 2^%0d", VALUE, WIDTH);
    end

    if (!REVERSE) begin : g_direct
        assign key = cnt;
    end else if (WIDTH == u_pkg::WIDTH) begin : g_rev_pkg
        assign key = u_pkg::bitrev(cnt);
    end else begin : g_rev_gen
        always_comb begin
            key = '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                key[i] = cnt[int'(WIDTH) - 1 - i];
            end
        end
    end

    // Compare one bit wider so VALUE = 2^WIDTH yields a constant 1.
    assign bit_c = ({1'b0, key} < (WIDTH+1)'(VALUE));

endmodule

// File: rtl/u_test_circuit.sv
// Unary multiplier test block: two SNGs on a shared free-running counter,
// ANDed into a registered product bitstream.
module u_test_circuit #(
    parameter int unsigned WIDTH = u_pkg::WIDTH,
    parameter int unsigned A_VAL = u_pkg::A_DEFAULT,
    parameter int unsigned B_VAL = u_pkg::B_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    output logic io_out
);

    logic [WIDTH-1:0] cnt;
    logic             a_c;
    logic             b_c;

    // Shared period counter; wraps naturally at 2^WIDTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    u_sng #(
        .WIDTH  (WIDTH),
        .VALUE  (A_VAL),
        .REVERSE(1'b0)
    ) u_sng_a (
        .cnt  (cnt),
        .bit_c(a_c)
    );

    u_sng #(
        .WIDTH  (WIDTH),
        .VALUE  (B_VAL),
        .REVERSE(1'b1)
    ) u_sng_b (
        .cnt  (cnt),
        .bit_c(b_c)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_out <= 1'b0;
        end else begin
            io_out <= a_c & b_c;
        end
    end

endmodule

// File: tb/tb_u_test_circuit.sv
// Bench for u_test_circuit: five parameterisations driven by one clock/reset,
// checked cycle by cycle and per period against an arithmetic reference.
module tb_u_test_circuit;

    localparam int unsigned W  = 7;
    localparam int unsigned P  = 128;
    localparam int          NI = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NI-1:0] io;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned k     = 0;
    int unsigned ones [NI];

    always #5 clock = ~clock;

    u_test_circuit u0 (.clock(clock), .reset(reset), .io_out(io[0]));
    u_test_circuit #(.WIDTH(W), .A_VAL(64),  .B_VAL(64))  u1 (.clock(clock), .reset(reset), .io_out(io[1]));
    u_test_circuit #(.WIDTH(W), .A_VAL(0),   .B_VAL(128)) u2 (.clock(clock), .reset(reset), .io_out(io[2]));
    u_test_circuit #(.WIDTH(W), .A_VAL(128), .B_VAL(128)) u3 (.clock(clock), .reset(reset), .io_out(io[3]));
    u_test_circuit #(.WIDTH(W), .A_VAL(128), .B_VAL(40))  u4 (.clock(clock), .reset(reset), .io_out(io[4]));

    function automatic int unsigned a_of(int i);
        case (i)
            0: return 96;
            1: return 64;
            2: return 0;
            default: return 128;
        endcase
    endfunction

    function automatic int unsigned b_of(int i);
        case (i)
            0: return 64;
            1: return 64;
            2: return 128;
            3: return 128;
            default: return 40;
        endcase
    endfunction

    // Ones per period expected from the multiplier arithmetic.
    function automatic int unsigned n_of(int i);
        case (i)
            0: return 48;
            1: return 32;
            2: return 0;
            3: return 128;
            default: return 40;
        endcase
    endfunction

    function automatic int unsigned brev(int unsigned c);
        int unsigned r = 0;
        for (int i = 0; i < int'(W); i++) begin
            r = r | (((c >> i) & 1) << (int'(W) - 1 - i));
        end
        return r;
    endfunction

    function automatic logic ref_bit(int i, int unsigned c);
        return (c < a_of(i)) && (brev(c) < b_of(i));
    endfunction

    task automatic chk(string tag, int unsigned obs, int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_io%0d", tag, i), 32'(io[i]), 0);
        end
        chk($sformatf("%s_cnt", tag), 32'(u0.cnt), 0);
    endtask

    // Advance n cycles after release, checking every instance each cycle.
    task automatic run_cycles(int unsigned n);
        for (int unsigned j = 0; j < n; j++) begin
            @(negedge clock);
            k++;
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("bit_i%0d_k%0d", i, k), 32'(io[i]), 32'(ref_bit(i, (k - 1) % P)));
                ones[i] += 32'(io[i]);
            end
        end
    endtask

    task automatic run_period(string tag);
        for (int i = 0; i < NI; i++) ones[i] = 0;
        run_cycles(P);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_ones_i%0d", tag, i), ones[i], n_of(i));
        end
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        #1;
        chk_all_zero("post_release");
    endtask

    initial begin
        int unsigned c;
        int unsigned off;

        // Reset held for five cycles: everything stays cleared.
        #1;
        chk_all_zero("reset_t0");
        for (int j = 0; j < 5; j++) begin
            @(negedge clock);
            chk_all_zero($sformatf("reset_hold%0d", j));
        end

        release_reset();
        run_period("p1");
        run_period("p2");

        // Asynchronous reset mid-period at a random cycle where u0 outputs 1.
        for (int r = 0; r < 2; r++) begin
            c = $urandom_range(P - 2, 2);
            while (!ref_bit(0, c - 1)) c = $urandom_range(P - 2, 2);
            off = $urandom_range(4, 1);
            for (int i = 0; i < NI; i++) ones[i] = 0;
            run_cycles(c);
            chk($sformatf("pre_rst%0d_io0", r), 32'(io[0]), 1);
            #(off);
            reset = 1'b1;
            #1;
            chk_all_zero($sformatf("async_rst%0d", r));
            @(negedge clock);
            chk_all_zero($sformatf("rst_held%0d", r));
            release_reset();
            run_period($sformatf("after_rst%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
